// File: rtl/dtcm_arbiter_if.sv
// Bus bundle between the CPU port, the DMA/loader port and the single-port DTCM.
// The arbiter takes the slave view; whatever drives requests and returns mem_rdata takes the master view.
interface dtcm_arbiter_if;
    logic        cpu_req;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;

    logic        dma_req;
    logic [3:0]  dma_wen;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;

    logic [31:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
        input  dma_req, dma_wen, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_wen, mem_wdata
    );

    modport master (
        output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
        output dma_req, dma_wen, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_wen, mem_wdata
    );
endinterface

// File: rtl/dtcm_arbiter.sv
// CPU/DMA arbiter for the single-port DTCM: CPU priority with bounded DMA starvation,
// one-cycle read return steered to whichever side owned the read.
module dtcm_arbiter #(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned DMA_BURST = 2
) (
    input  logic           clk,
    input  logic           reset,
    dtcm_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        CPU_PRI = 1'b0,
        DMA_PRI = 1'b1
    } state_e;

    localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
    localparam logic [3:0] DMA_BURST_C = 4'(DMA_BURST);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  burst_q, burst_d;
    logic [1:0]  rd_owner_q, rd_owner_d;
    logic        hold_q, hold_d;

    logic        cpu_gnt_s;
    logic        dma_gnt_s;
    logic        blocked_s;
    logic        cpu_rvalid_s;
    logic        dma_rvalid_s;

    // Arbitration FSM: next state, starvation/burst counters and grants.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        burst_d   = burst_q;
        cpu_gnt_s = 1'b0;
        dma_gnt_s = 1'b0;
        // No grants in the reset cycle nor in the cycle right after it.
        blocked_s = reset | hold_q;

        if (blocked_s) begin
            state_d = CPU_PRI;
            wait_d  = 4'd0;
            burst_d = 4'd0;
        end else begin
            case (state_q)
                CPU_PRI: begin
                    if (bus.dma_req && (wait_q == MAX_WAIT_C)) begin
                        dma_gnt_s = 1'b1;
                        burst_d   = 4'd1;
                        // A burst of one is fully spent by this forced grant.
                        state_d   = (DMA_BURST_C > 4'd1) ? DMA_PRI : CPU_PRI;
                    end else if (bus.cpu_req) begin
                        cpu_gnt_s = 1'b1;
                    end else if (bus.dma_req) begin
                        dma_gnt_s = 1'b1;
                    end else begin
                        state_d = CPU_PRI;
                    end
                end
                DMA_PRI: begin
                    if (bus.dma_req) begin
                        dma_gnt_s = 1'b1;
                        if ((burst_q + 4'd1) >= DMA_BURST_C) begin
                            state_d = CPU_PRI;
                            burst_d = 4'd0;
                        end else begin
                            burst_d = burst_q + 4'd1;
                        end
                    end else begin
                        cpu_gnt_s = bus.cpu_req;
                        state_d   = CPU_PRI;
                        burst_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = CPU_PRI;
                    burst_d = 4'd0;
                end
            endcase

            if (bus.dma_req && !dma_gnt_s) begin
                wait_d = (wait_q >= MAX_WAIT_C) ? MAX_WAIT_C : (wait_q + 4'd1);
            end else begin
                wait_d = 4'd0;
            end
        end
    end

    // Memory-side mux and read-ownership capture for the next cycle.
    always_comb begin
        rd_owner_d    = {cpu_gnt_s && (bus.cpu_wen == 4'h0), dma_gnt_s && (bus.dma_wen == 4'h0)};
        hold_d        = reset;
        bus.cpu_gnt   = cpu_gnt_s;
        bus.dma_gnt   = dma_gnt_s;
        if (dma_gnt_s) begin
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wen   = bus.dma_wen;
            bus.mem_wdata = bus.dma_wdata;
        end else if (cpu_gnt_s) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wen   = bus.cpu_wen;
            bus.mem_wdata = bus.cpu_wdata;
        end else begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wen   = 4'h0;
            bus.mem_wdata = bus.cpu_wdata;
        end
    end

    // Read return: data from the DTCM goes only to the side that owned the read.
    always_comb begin
        cpu_rvalid_s   = rd_owner_q[1] && !reset;
        dma_rvalid_s   = rd_owner_q[0] && !reset;
        bus.cpu_rvalid = cpu_rvalid_s;
        bus.dma_rvalid = dma_rvalid_s;
        bus.cpu_rdata  = cpu_rvalid_s ? bus.mem_rdata : 32'h0000_0000;
        bus.dma_rdata  = dma_rvalid_s ? bus.mem_rdata : 32'h0000_0000;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CPU_PRI;
            wait_q     <= 4'd0;
            burst_q    <= 4'd0;
            rd_owner_q <= 2'b00;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            burst_q    <= burst_d;
            rd_owner_q <= rd_owner_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Self-checking bench for dtcm_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model expressed in terms of starvation streak and remaining burst grants.
module tb_dtcm_arbiter;

    localparam int MAX_WAIT  = 4;
    localparam int DMA_BURST = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dtcm_arbiter_if bus ();

    dtcm_arbiter #(.MAX_WAIT(MAX_WAIT), .DMA_BURST(DMA_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int m_starve;
    int m_burst_left;
    bit m_hold;
    bit m_prev_c;
    bit m_prev_d;

    logic        exp_cg, exp_dg, exp_cv, exp_dv, exp_forced;
    logic [3:0]  exp_wen;
    logic [31:0] exp_addr, exp_wdata, exp_crd, exp_drd;

    task automatic model_eval();
        exp_cg     = 1'b0;
        exp_dg     = 1'b0;
        exp_forced = 1'b0;
        if (!reset && !m_hold) begin
            if (m_burst_left > 0) begin
                if (bus.dma_req) exp_dg = 1'b1;
                else             exp_cg = bus.cpu_req;
            end else if (bus.dma_req && m_starve >= MAX_WAIT) begin
                exp_dg     = 1'b1;
                exp_forced = 1'b1;
            end else if (bus.cpu_req) begin
                exp_cg = 1'b1;
            end else begin
                exp_dg = bus.dma_req;
            end
        end
        exp_wen   = exp_cg ? bus.cpu_wen   : (exp_dg ? bus.dma_wen : 4'h0);
        exp_addr  = exp_dg ? bus.dma_addr  : bus.cpu_addr;
        exp_wdata = exp_dg ? bus.dma_wdata : bus.cpu_wdata;
        exp_cv    = !reset && m_prev_c;
        exp_dv    = !reset && m_prev_d;
        exp_crd   = exp_cv ? bus.mem_rdata : 32'h0;
        exp_drd   = exp_dv ? bus.mem_rdata : 32'h0;
    endtask

    task automatic model_commit();
        if (reset) begin
            m_starve = 0; m_burst_left = 0; m_prev_c = 1'b0; m_prev_d = 1'b0; m_hold = 1'b1;
        end else begin
            if (m_hold)                     m_starve = 0;
            else if (bus.dma_req && !exp_dg) m_starve = (m_starve + 1 > MAX_WAIT) ? MAX_WAIT : m_starve + 1;
            else                            m_starve = 0;
            if (m_burst_left > 0) m_burst_left = exp_dg ? m_burst_left - 1 : 0;
            else if (exp_forced)  m_burst_left = DMA_BURST - 1;
            m_prev_c = exp_cg && (bus.cpu_wen == 4'h0);
            m_prev_d = exp_dg && (bus.dma_wen == 4'h0);
            m_hold   = 1'b0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 1'b0; bus.cpu_wen = 4'h0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
        bus.dma_req = 1'b0; bus.dma_wen = 4'h0; bus.dma_addr = 32'h0; bus.dma_wdata = 32'h0;
        bus.mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if ({bus.cpu_gnt, bus.dma_gnt, bus.cpu_rvalid, bus.dma_rvalid} !== 4'b0000 || bus.mem_wen !== 4'h0) begin
                errors++;
                $display("FAIL reset_quiet cyc=%0d got gnt=%b%b rv=%b%b wen=%h exp all 0", c,
                         bus.cpu_gnt, bus.dma_gnt, bus.cpu_rvalid, bus.dma_rvalid, bus.mem_wen);
            end
            tick();
            reset = 1'b0;
        end
        settle();
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_gnt got cpu=%b dma=%b exp cpu=1 dma=0", bus.cpu_gnt, bus.dma_gnt);
        end
        tick();
        idle_inputs();
        settle(); tick();
    endtask

    task automatic test_cpu_read();
        bus.cpu_req = 1'b1; bus.cpu_wen = 4'h0; bus.cpu_addr = 32'h0000_0100;
        settle();
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wen !== 4'h0) begin
            errors++;
            $display("FAIL cpu_read_gnt got gnt=%b addr=%h wen=%h exp 1/00000100/0", bus.cpu_gnt, bus.mem_addr, bus.mem_wen);
        end
        tick();
        bus.cpu_req = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
        settle();
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEAD_BEEF || bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 32'h0) begin
            errors++;
            $display("FAIL cpu_read_ret got rv=%b rd=%h drv=%b drd=%h exp 1/deadbeef/0/0",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.dma_rdata);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic [11:0] pat;
        pat = 12'b0000_11_0000_11;
        bus.cpu_req = 1'b1; bus.cpu_wen = 4'hF; bus.dma_req = 1'b1; bus.dma_wen = 4'hF;
        for (int i = 0; i < 12; i++) begin
            settle();
            checks++;
            if (bus.dma_gnt !== pat[11-i] || bus.cpu_gnt !== !pat[11-i]) begin
                errors++;
                $display("FAIL starve_pattern cyc=%0d got cpu=%b dma=%b exp dma=%b", i, bus.cpu_gnt, bus.dma_gnt, pat[11-i]);
            end
            tick();
        end
        idle_inputs();
        settle(); tick();
    endtask

    task automatic test_dma_write();
        bus.dma_req = 1'b1; bus.dma_wen = 4'hF; bus.dma_addr = 32'h20; bus.dma_wdata = 32'h1234_5678;
        settle();
        checks++;
        if (bus.dma_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0 || bus.mem_wen !== 4'hF ||
            bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL dma_write got gnt=%b wen=%h addr=%h data=%h exp 1/f/00000020/12345678",
                     bus.dma_gnt, bus.mem_wen, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        idle_inputs();
        settle();
        checks++;
        if (bus.dma_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL dma_write_norv got rvalid=%b exp 0", bus.dma_rvalid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.cpu_req = 1'b1; bus.cpu_wen = 4'h0; bus.cpu_addr = 32'h0;
        settle();
        checks++;
        if (bus.cpu_gnt !== 1'b1) begin
            errors++; $display("FAIL b2b_cpu_gnt got %b exp 1", bus.cpu_gnt);
        end
        tick();
        bus.cpu_req = 1'b0; bus.dma_req = 1'b1; bus.dma_wen = 4'h0; bus.dma_addr = 32'h4; bus.mem_rdata = 32'hA1A1_0001;
        settle();
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hA1A1_0001 || bus.dma_rvalid !== 1'b0 || bus.dma_gnt !== 1'b1) begin
            errors++;
            $display("FAIL b2b_cpu_ret got crv=%b crd=%h drv=%b dgnt=%b exp 1/a1a10001/0/1",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, bus.dma_gnt);
        end
        tick();
        bus.dma_req = 1'b0; bus.mem_rdata = 32'hB2B2_0002;
        settle();
        checks++;
        if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 32'hB2B2_0002 || bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL b2b_dma_ret got drv=%b drd=%h crv=%b crd=%h exp 1/b2b20002/0/0",
                     bus.dma_rvalid, bus.dma_rdata, bus.cpu_rvalid, bus.cpu_rdata);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_inflight();
        bus.cpu_req = 1'b1; bus.cpu_wen = 4'hF; bus.dma_req = 1'b1; bus.dma_wen = 4'h0; bus.dma_addr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            settle(); tick();
        end
        settle();
        checks++;
        if (bus.dma_gnt !== 1'b1 || m_burst_left == 0) begin
            errors++; $display("FAIL inflight_burst_gnt got dma_gnt=%b exp 1 in burst", bus.dma_gnt);
        end
        tick();
        reset = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 32'h0 || bus.cpu_gnt !== 1'b0 || bus.dma_gnt !== 1'b0) begin
                errors++;
                $display("FAIL inflight_drop cyc=%0d got drv=%b drd=%h gnt=%b%b exp 0/0/00", c,
                         bus.dma_rvalid, bus.dma_rdata, bus.cpu_gnt, bus.dma_gnt);
            end
            tick();
            reset = 1'b0;
        end
        settle();
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin
            errors++; $display("FAIL inflight_cpu_pri got cpu=%b dma=%b exp 1/0", bus.cpu_gnt, bus.dma_gnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 60) == 0);
            bus.cpu_req   = ($urandom_range(0, 3) != 0);
            bus.dma_req   = ($urandom_range(0, 2) != 0);
            bus.cpu_wen   = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            bus.dma_wen   = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            bus.cpu_addr  = $urandom; bus.dma_addr  = $urandom;
            bus.cpu_wdata = $urandom; bus.dma_wdata = $urandom;
            bus.mem_rdata = $urandom;
            settle();
            checks++;
            if (bus.cpu_gnt !== exp_cg || bus.dma_gnt !== exp_dg) begin
                errors++;
                $display("FAIL rnd_gnt cyc=%0d got cpu=%b dma=%b exp cpu=%b dma=%b", i, bus.cpu_gnt, bus.dma_gnt, exp_cg, exp_dg);
            end
            checks++;
            if (bus.mem_wen !== exp_wen || bus.mem_addr !== exp_addr || bus.mem_wdata !== exp_wdata) begin
                errors++;
                $display("FAIL rnd_mem cyc=%0d got wen=%h addr=%h data=%h exp wen=%h addr=%h data=%h", i,
                         bus.mem_wen, bus.mem_addr, bus.mem_wdata, exp_wen, exp_addr, exp_wdata);
            end
            checks++;
            if (bus.cpu_rvalid !== exp_cv || bus.cpu_rdata !== exp_crd) begin
                errors++;
                $display("FAIL rnd_cpu_ret cyc=%0d got rv=%b rd=%h exp rv=%b rd=%h", i, bus.cpu_rvalid, bus.cpu_rdata, exp_cv, exp_crd);
            end
            checks++;
            if (bus.dma_rvalid !== exp_dv || bus.dma_rdata !== exp_drd) begin
                errors++;
                $display("FAIL rnd_dma_ret cyc=%0d got rv=%b rd=%h exp rv=%b rd=%h", i, bus.dma_rvalid, bus.dma_rdata, exp_dv, exp_drd);
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        checks = 0; errors = 0;
        m_starve = 0; m_burst_left = 0; m_hold = 1'b1; m_prev_c = 1'b0; m_prev_d = 1'b0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_starvation();
        test_dma_write();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
